// File: rtl/aes_coproc_pkg.sv
// Shared types and constants for the AES coprocessor responder.
package aes_coproc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GATHER  = 2'd1,
      COMPUTE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   localparam int AES_WORDS = 4;
   localparam int BEAT_W    = 2;

   typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/aes_core.sv
// Single combinational cipher round shared by encrypt and decrypt:
// encrypt = AddRoundKey then a one-byte rotation towards the high end;
// decrypt undoes it (rotate back, then remove the key).
module aes_core (
   input  logic [127:0] data,
   input  logic [127:0] key,
   input  logic         dec,
   output logic [127:0] result
);

   logic [127:0] keyed;

   assign keyed  = data ^ key;
   assign result = dec ? ({data[7:0], data[127:8]} ^ key)
                       : {keyed[119:0], keyed[127:120]};

endmodule

// File: rtl/aes_coproc_resp.sv
// Responder end of the CPU AES-instruction interface: takes a command,
// gathers four key/data beats, runs aes_core, then streams four result
// words back with their destination register indices.
//
// state   | meaning
// IDLE    | waiting for a command; cmd_ready high unless flushing
// GATHER  | collecting operand beats 0..3 into key_buf / data_buf
// COMPUTE | core settling for COMPUTE_CYCLES cycles, then capture res_buf
// DRAIN   | presenting result beats 0..3; beat-3 handshake ends the op
module aes_coproc_resp
   import aes_coproc_pkg::*;
#(
   parameter int COMPUTE_CYCLES = 1,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dec,
   input  logic [4:0]       cmd_rd,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [31:0]      op_key,
   input  logic [31:0]      op_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_word,
   output logic [4:0]       res_rd,
   output logic             res_last,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(AES_WORDS - 1);
   localparam logic [3:0]        COMP_LAST = 4'(COMPUTE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t            state;
   logic [BEAT_W-1:0] beat;
   logic [3:0]        comp_cnt;
   logic [127:0]      key_buf;
   logic [127:0]      data_buf;
   logic [127:0]      res_buf;
   logic [127:0]      core_out;
   logic              dec_q;
   reg_idx_t          rd_base;
   logic              cmd_hs;
   logic              op_hs;
   logic              res_hs;

   aes_core u_core (
      .data   (data_buf),
      .key    (key_buf),
      .dec    (dec_q),
      .result (core_out)
   );

   // Readies and res_valid drop during flush so no handshake can land in that cycle.
   assign cmd_ready = (state == IDLE)   & ~flush;
   assign op_ready  = (state == GATHER) & ~flush;
   assign res_valid = (state == DRAIN)  & ~flush;
   assign busy      = (state != IDLE);

   // Result data is a pure function of registered state, zero outside DRAIN.
   assign res_word = (state == DRAIN) ? res_buf[{beat, 5'd0} +: 32] : '0;
   assign res_rd   = (state == DRAIN) ? reg_idx_t'(rd_base + reg_idx_t'(beat)) : '0;
   assign res_last = (state == DRAIN) & (beat == LAST_BEAT);

   assign cmd_hs = cmd_valid & cmd_ready;
   assign op_hs  = op_valid  & op_ready;
   assign res_hs = res_valid & res_ready;

   // Sequencer: flush beats every state transition; op_count only moves on the final result beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         beat     <= '0;
         comp_cnt <= '0;
         key_buf  <= '0;
         data_buf <= '0;
         res_buf  <= '0;
         dec_q    <= 1'b0;
         rd_base  <= '0;
         op_count <= '0;
      end else if (flush) begin
         state    <= IDLE;
         beat     <= '0;
         comp_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_hs) begin
                  dec_q   <= cmd_dec;
                  rd_base <= cmd_rd;
                  beat    <= '0;
                  state   <= GATHER;
               end
            end
            GATHER: begin
               if (op_hs) begin
                  key_buf[{beat, 5'd0} +: 32]  <= op_key;
                  data_buf[{beat, 5'd0} +: 32] <= op_data;
                  beat                         <= beat + 1'b1;
                  if (beat == LAST_BEAT) begin
                     comp_cnt <= '0;
                     state    <= COMPUTE;
                  end
               end
            end
            COMPUTE: begin
               comp_cnt <= comp_cnt + 1'b1;
               if (comp_cnt == COMP_LAST) begin
                  res_buf <= core_out;
                  beat    <= '0;
                  state   <= DRAIN;
               end
            end
            DRAIN: begin
               if (res_hs) begin
                  beat <= beat + 1'b1;
                  if (beat == LAST_BEAT) begin
                     state <= IDLE;
                     if (op_count != CNT_MAX) begin
                        op_count <= op_count + 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_coproc_resp.sv
// Bench for aes_coproc_resp: two instances (COMPUTE_CYCLES=1/CNT_W=16 and
// COMPUTE_CYCLES=5/CNT_W=2), a byte-level cipher model, an expected-beat
// queue and one compare process watching both result channels.
module tb_aes_coproc_resp;

   typedef logic [3:0][31:0] quad_t;
   typedef struct {
      int          d;
      logic [31:0] word;
      logic [4:0]  rd;
      logic        last;
   } beat_t;

   localparam int BUDGET = 300;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset_n;
   logic [1:0]       flush, cmd_valid, cmd_dec, op_valid, res_ready;
   logic [1:0][4:0]  cmd_rd;
   logic [1:0][31:0] op_key, op_data;
   logic [1:0]       cmd_ready, op_ready, res_valid, res_last, busy;
   logic [1:0][31:0] res_word;
   logic [1:0][4:0]  res_rd;
   logic [15:0]      op_count0;
   logic [1:0]       op_count1;

   aes_coproc_resp #(.COMPUTE_CYCLES(1), .CNT_W(16)) dut0 (
      .clk(clk), .reset_n(reset_n), .flush(flush[0]),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_dec(cmd_dec[0]), .cmd_rd(cmd_rd[0]),
      .op_valid(op_valid[0]), .op_ready(op_ready[0]), .op_key(op_key[0]), .op_data(op_data[0]),
      .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_word(res_word[0]), .res_rd(res_rd[0]),
      .res_last(res_last[0]), .busy(busy[0]), .op_count(op_count0)
   );

   aes_coproc_resp #(.COMPUTE_CYCLES(5), .CNT_W(2)) dut1 (
      .clk(clk), .reset_n(reset_n), .flush(flush[1]),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_dec(cmd_dec[1]), .cmd_rd(cmd_rd[1]),
      .op_valid(op_valid[1]), .op_ready(op_ready[1]), .op_key(op_key[1]), .op_data(op_data[1]),
      .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_word(res_word[1]), .res_rd(res_rd[1]),
      .res_last(res_last[1]), .busy(busy[1]), .op_count(op_count1)
   );

   int    cyc = 0;
   int    n_cmp = 0;
   int    n_err = 0;
   int    last_hs = 0;
   int    exp_cnt [2] = '{0, 0};
   beat_t exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out after %0d cycles (t=%0t)", name, BUDGET, $time);
   endtask

   // Cipher defined byte-wise: encrypt puts (data^key) byte i-1 into byte i
   // (byte 15 wraps to byte 0); decrypt takes data byte i+1 then XORs key byte i.
   function automatic quad_t model(quad_t data, quad_t key, bit dec);
      logic [127:0] d, k, r;
      d = data;
      k = key;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (dec) r[8*i +: 8] = d[8*((i + 1) % 16) +: 8] ^ k[8*i +: 8];
         else     r[8*i +: 8] = d[8*((i + 15) % 16) +: 8] ^ k[8*((i + 15) % 16) +: 8];
      end
      return r;
   endfunction

   function automatic logic [15:0] cnt_of(int d);
      return (d == 0) ? op_count0 : {14'd0, op_count1};
   endfunction

   function automatic quad_t rand_quad();
      quad_t q;
      for (int k = 0; k < 4; k++) q[k] = $urandom();
      return q;
   endfunction

   // Compare process: readies silent under flush, stalled outputs hold,
   // every consumed beat matches the head of the expected queue.
   logic [1:0]       stall_prev;
   logic [1:0][31:0] word_prev;
   logic [1:0][4:0]  rd_prev;
   beat_t            e;
   always @(negedge clk) begin
      if (!reset_n) begin
         stall_prev <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (flush[i]) check($sformatf("flush_quiet%0d", i), {cmd_ready[i], op_ready[i], res_valid[i]}, 0);
            if (stall_prev[i] && res_valid[i]) begin
               check($sformatf("stall_word%0d", i), res_word[i], word_prev[i]);
               check($sformatf("stall_rd%0d", i), res_rd[i], rd_prev[i]);
            end
            if (res_valid[i] && res_ready[i]) begin
               if (exp_q.size() == 0 || exp_q[0].d != i) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_beat dut%0d: got word %h rd %0d, expected no beat", i, res_word[i], res_rd[i]);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("res_word%0d", i), res_word[i], e.word);
                  check($sformatf("res_rd%0d", i), res_rd[i], e.rd);
                  check($sformatf("res_last%0d", i), res_last[i], e.last);
               end
            end
            stall_prev[i] <= res_valid[i] && !res_ready[i];
            word_prev[i]  <= res_word[i];
            rd_prev[i]    <= res_rd[i];
         end
      end
   end

   task automatic wait_ready(int d, bit is_cmd, string name);
      int n = 0;
      forever begin
         @(negedge clk);
         if (is_cmd ? cmd_ready[d] : op_ready[d]) break;
         n++;
         if (n > BUDGET) begin
            timeout(name);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(int d, bit dec, logic [4:0] rd);
      cmd_valid[d] = 1'b1;
      cmd_dec[d]   = dec;
      cmd_rd[d]    = rd;
      wait_ready(d, 1'b1, "cmd_handshake");
      cmd_valid[d] = 1'b0;
   endtask

   task automatic send_beats(int d, quad_t key, quad_t data, int gap);
      for (int k = 0; k < 4; k++) begin
         if (k > 0 && gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         op_valid[d] = 1'b1;
         op_key[d]   = key[k];
         op_data[d]  = data[k];
         wait_ready(d, 1'b0, "op_handshake");
         op_valid[d] = 1'b0;
         last_hs     = cyc;
      end
   endtask

   task automatic wait_valid(int d);
      int n = 0;
      forever begin
         @(negedge clk);
         if (res_valid[d]) break;
         n++;
         if (n > BUDGET) begin
            timeout("res_valid_rise");
            break;
         end
      end
   endtask

   // bp: 0 = res_ready tied high, 1 = pattern 1,0,0,..., 2 = random
   task automatic run_op(int d, bit dec, logic [4:0] rd, quad_t key, quad_t data, int gap, int bp);
      quad_t       r;
      logic [4:0]  rr;
      int          j = 1;
      int          n = 0;
      r = model(data, key, dec);
      for (int k = 0; k < 4; k++) begin
         rr = rd + 5'(k);
         exp_q.push_back('{d, r[k], rr, (k == 3)});
      end
      do_cmd(d, dec, rd);
      send_beats(d, key, data, gap);
      res_ready[d] = 1'b1;
      wait_valid(d);
      check($sformatf("latency%0d", d), cyc - last_hs, (d == 0) ? 1 : 5);
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) break;
         res_ready[d] = (bp == 0) ? 1'b1 : (bp == 1) ? (j % 3 == 0) : 1'($urandom_range(0, 1));
         j++;
         n++;
         if (n > BUDGET) begin
            timeout("drain");
            exp_q.delete();
            break;
         end
      end
      res_ready[d] = 1'b0;
      check($sformatf("busy_after_last%0d", d), busy[d], 0);
      if (exp_cnt[d] < ((d == 0) ? 65535 : 3)) exp_cnt[d]++;
      check($sformatf("op_count%0d", d), cnt_of(d), exp_cnt[d]);
   endtask

   task automatic check_reset_vals(int d);
      check($sformatf("rst_cmd_ready%0d", d), cmd_ready[d], 1);
      check($sformatf("rst_op_ready%0d", d), op_ready[d], 0);
      check($sformatf("rst_res_valid%0d", d), res_valid[d], 0);
      check($sformatf("rst_res_word%0d", d), res_word[d], 0);
      check($sformatf("rst_res_rd%0d", d), res_rd[d], 0);
      check($sformatf("rst_res_last%0d", d), res_last[d], 0);
      check($sformatf("rst_busy%0d", d), busy[d], 0);
      check($sformatf("rst_op_count%0d", d), cnt_of(d), 0);
   endtask

   quad_t bkey, bdata, gold;

   initial begin
      reset_n   = 1'b0;
      flush     = '0;
      cmd_valid = '0;
      cmd_dec   = '0;
      cmd_rd    = '0;
      op_valid  = '0;
      op_key    = '0;
      op_data   = '0;
      res_ready = '0;
      #1;
      check_reset_vals(0);
      check_reset_vals(1);

      bkey  = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
      bdata = {32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100};
      gold  = model(bdata, bkey, 1'b0);
      check("model_enc_literal", gold, 128'he0d0c0b0_a0908070_60504030_201000f0);
      check("model_roundtrip", model(gold, bkey, 1'b1), bdata);

      #2 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // basic encrypt, decrypt under backpressure, rd wrap with gaps
      run_op(0, 1'b0, 5'd10, bkey, bdata, 0, 0);
      run_op(0, 1'b1, 5'd20, rand_quad(), rand_quad(), 0, 1);
      run_op(0, 1'($urandom_range(0, 1)), 5'd30, rand_quad(), rand_quad(), 2, 0);
      run_op(1, 1'b0, 5'd7, bkey, bdata, 0, 0);

      // flush after three gather beats, with cmd_valid and op_valid high
      do_cmd(0, 1'b0, 5'd3);
      for (int k = 0; k < 3; k++) begin
         op_valid[0] = 1'b1;
         op_key[0]   = $urandom();
         op_data[0]  = $urandom();
         wait_ready(0, 1'b0, "op_handshake");
      end
      flush[0]     = 1'b1;
      cmd_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      flush[0]     = 1'b0;
      cmd_valid[0] = 1'b0;
      op_valid[0]  = 1'b0;
      check("flush_gather_busy", busy[0], 0);
      check("flush_gather_count", cnt_of(0), exp_cnt[0]);
      flush[0]     = 1'b1;
      cmd_valid[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      flush[0]     = 1'b0;
      cmd_valid[0] = 1'b0;
      check("flush_idle_busy", busy[0], 0);

      // flush in the middle of DRAIN
      gold = model(bdata, bkey, 1'b1);
      for (int k = 0; k < 4; k++) exp_q.push_back('{0, gold[k], 5'(12 + k), (k == 3)});
      do_cmd(0, 1'b1, 5'd12);
      send_beats(0, bkey, bdata, 0);
      wait_valid(0);
      @(posedge clk);
      #1;
      res_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      res_ready[0] = 1'b0;
      @(posedge clk);
      #1;
      flush[0]     = 1'b1;
      res_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      flush[0]     = 1'b0;
      res_ready[0] = 1'b0;
      check("flush_drain_left", exp_q.size(), 3);
      exp_q.delete();
      check("flush_drain_busy", busy[0], 0);
      check("flush_drain_count", cnt_of(0), exp_cnt[0]);

      // clean operations after the flushes, randomized
      for (int t = 0; t < 6; t++)
         run_op(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rand_quad(), rand_quad(),
                $urandom_range(0, 2), 2);

      // asynchronous reset in the middle of COMPUTE
      do_cmd(1, 1'b0, 5'd1);
      send_beats(1, rand_quad(), rand_quad(), 0);
      @(posedge clk);
      #2;
      check("busy_before_reset", busy[1], 1);
      reset_n = 1'b0;
      #1;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      check_reset_vals(0);
      check_reset_vals(1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // saturation of the 2-bit counter
      for (int t = 0; t < 5; t++)
         run_op(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rand_quad(), rand_quad(),
                $urandom_range(0, 1), 2);
      check("sat_count_literal", op_count1, 2'd3);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aes_coproc_resp.md
Name: aes_coproc_resp

Overview:
- Responder end of the CPU AES-instruction interface: accepts a command, gathers 4 key/data word pairs, runs the shared aes_core, then streams 4 result words back for register writeback.
- Lets the CPU core offload the AES gather/compute/writeback sequence to a decoupled coprocessor with valid/ready handshakes on every channel.
- Sits between the CPU issue logic and its register-file write port.

Parameters:
- COMPUTE_CYCLES, 1, cycles spent in COMPUTE before the result is captured (1..15); models a multi-cycle core.
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; returns the FSM to IDLE
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_dec  in  1  0 = encrypt, 1 = decrypt
- cmd_rd  in  5  destination register base
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accepted when op_valid & op_ready
- op_key  in  32  key word for the current beat
- op_data  in  32  data word for the current beat
- res_valid  out  1  result beat valid
- res_ready  in  1  result beat consumed when res_valid & res_ready
- res_word  out  32  result word
- res_rd  out  5  destination register for this word
- res_last  out  1  high on beat 3
- busy  out  1  high whenever state != IDLE
- op_count  out  CNT_W  number of completed operations, saturating

Behaviour:
- Reset: clk and reset_n as already decided; reset_n is asynchronous, active-low.
- Reset values: state IDLE; beat counter 0; compute counter 0; key_buf, data_buf and res_buf 0; op_count 0.
- Output values in reset: cmd_ready=1, op_ready=0, res_valid=0, res_word=0, res_rd=0, res_last=0, busy=0.
- States: IDLE, GATHER, COMPUTE, DRAIN.
- IDLE:
  - cmd_ready = !flush.
  - On a command handshake, latch cmd_dec and cmd_rd, clear the beat counter, go to GATHER.
- GATHER:
  - op_ready = !flush.
  - Beat k (0..3) writes key_buf[32k+31:32k] <= op_key and data_buf[32k+31:32k] <= op_data; beat 0 is the low word.
  - Idle cycles (op_valid low) do not advance the beat counter.
  - After the handshake on beat 3, go to COMPUTE with the compute counter at 0.
- COMPUTE:
  - aes_core is driven from data_buf, key_buf and the latched dec bit.
  - The counter increments each cycle.
  - In the cycle the counter reaches COMPUTE_CYCLES-1: res_buf <= core output, beat counter cleared, go to DRAIN.
  - Minimum operand-to-result latency: last op handshake, then COMPUTE_CYCLES cycles, then res_valid=1.
- DRAIN:
  - res_valid = 1.
  - res_word = res_buf[32k+31:32k].
  - res_rd = rd_base + k, 5-bit wrap (base 30 gives 30, 31, 0, 1).
  - res_last = (k==3).
  - All result outputs are registered or a pure function of registered state, and hold stable while res_ready is low.
  - The beat-3 handshake increments op_count (saturating at all-ones) and returns to IDLE.
  - A new command is accepted no earlier than the cycle after return to IDLE.
- flush:
  - Highest priority in every state: next state IDLE, counters cleared, no op_count increment.
  - All ready outputs are forced low while flush=1, so no handshake completes in a flush cycle.
  - Buffers may keep stale contents.
  - res_valid is forced 0 in the flush cycle.
- No handshake on one channel is accepted in a state that does not own that channel.
  - op_valid in IDLE or DRAIN is ignored.
  - cmd_valid outside IDLE is ignored, with cmd_ready=0.
- Reset asserted mid-operation: immediate return to the reset values; op_count is cleared.

Decomposition:
- Package aes_coproc_pkg holds:
  - the state enum (IDLE=0, GATHER=1, COMPUTE=2, DRAIN=3);
  - AES_WORDS=4 and BEAT_W=2;
  - the 5-bit register-index type.
- Single sub-module: the existing aes_core, instantiated once. The combinational round is not duplicated.
- Counters and the FSM live in this module.

Test Plan:
- Basic encrypt:
  - Stimulus: cmd(dec=0, rd=10); beats key={03020100,07060504,0b0a0908,0f0e0d0c}, data={33221100,77665544,bbaa9988,ffeeddcc}; res_ready tied 1.
  - Response: 4 beats with res_rd 10..13; words equal a standalone aes_core golden output for that data and key, low word first; res_last only on the 4th beat; op_count=1.
- Decrypt with backpressure:
  - Stimulus: dec=1, rd=20; res_ready toggled 1,0,0,1,...
  - Response: res_word and res_rd stable while stalled; exactly 4 handshakes; golden-equal words; busy drops on the cycle after beat 3.
- Register wrap and gaps:
  - Stimulus: rd=30; op_valid with 2-cycle gaps between beats.
  - Response: res_rd sequence 30, 31, 0, 1; the gaps neither skip nor duplicate beats.
- Latency:
  - Stimulus: COMPUTE_CYCLES=1 and then 5.
  - Response: res_valid rises exactly 1 and 5 cycles after the last op handshake, respectively.
- Flush:
  - Stimulus: flush asserted after beat 2 of GATHER, then again mid-DRAIN; flush held concurrently with cmd_valid.
  - Response: busy=0 the next cycle; op_count unchanged; no handshake while flush=1; a following clean operation produces correct results.
- Reset and saturation:
  - Stimulus: reset_n pulsed low mid-COMPUTE; separately, CNT_W=2 with 5 operations.
  - Response: all outputs return to their reset values asynchronously; op_count reads 3 after 5 operations.
